pair_triple_event_counter: RTL and testbench

Debounced event counter that sits directly downstream of the pair/triple (2-of-3 majority) detector and consumes its single-bit `out`. It qualifies the detector output with a sample-valid strobe and requires the detection to hold for a programmable number of valid samples. It then emits a one-cycle event pulse and increments a saturating event count. Software and debug logic read the count. The event pulse feeds later control stages.

---
 rtl/pair_triple_event_counter.sv | 128 ++++++++++++
 tb/tb_pair_triple_event_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pair_triple_event_counter.sv
// Debounced event counter behind the 2-of-3 pair/triple detector: qualifies in_det_i with
// in_val_i, requires HOLD_CYCLES valid high samples, then pulses event_o and bumps count_o.
// Optional macro PAIR_TRIPLE_EVENT_COUNTER_WRAP_EN: count wraps and sat_o becomes a sticky overflow flag.
//
// Handshake: in_val_i is a qualifier only (no ready); a cycle with in_val_i = 0 holds all state
// and produces no event. clear_i is synchronous and overrides everything in its cycle.
module pair_triple_event_counter #(
  parameter int COUNT_WIDTH = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_val_i,
  input  logic                   in_det_i,
  input  logic                   clear_i,
  output logic                   event_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   sat_o,
  output logic                   active_o,
  output logic [1:0]             state_o
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]      HOLD_TGT = HOLD_W'(HOLD_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d, hold_inc;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   sat_q, sat_d;
  logic                   event_q, event_d;
  logic                   fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      event_q <= event_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    count_d  = count_q;
    sat_d    = sat_q;
    event_d  = 1'b0;
    fire     = 1'b0;
    hold_inc = hold_q + 1'b1;

    if (clear_i) begin
      state_d = IDLE;
      hold_d  = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (in_val_i) begin
        case (state_q)
          IDLE: begin
            if (in_det_i) begin
              if (HOLD_CYCLES == 1) begin
                fire    = 1'b1;
                state_d = HELD;
              end else begin
                state_d = ARM;
                hold_d  = HOLD_W'(1);
              end
            end
          end
          ARM: begin
            if (in_det_i) begin
              if (hold_inc == HOLD_TGT) begin
                fire    = 1'b1;
                hold_d  = '0;
                state_d = HELD;
              end else begin
                hold_d = hold_inc;
              end
            end else begin
              // Detection dropped before the hold completed: treat as a glitch.
              state_d = IDLE;
              hold_d  = '0;
            end
          end
          HELD: begin
            if (!in_det_i) state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
            hold_d  = '0;
          end
        endcase
      end

      if (fire) begin
        event_d = 1'b1;
`ifdef PAIR_TRIPLE_EVENT_COUNTER_WRAP_EN
        count_d = count_q + 1'b1;
        if (count_q == CNT_MAX) sat_d = 1'b1;
`else
        if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        sat_d = (count_d == CNT_MAX);
`endif
      end
    end
  end

  assign event_o  = event_q;
  assign count_o  = count_q;
  assign sat_o    = sat_q;
  assign active_o = (state_q != IDLE);
  assign state_o  = state_q;

endmodule

// File: tb/tb_pair_triple_event_counter.sv
// Directed bench for pair_triple_event_counter: HOLD_CYCLES=2 and HOLD_CYCLES=1 instances, COUNT_WIDTH=4.
module tb_pair_triple_event_counter;

  localparam int CW = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          val = 1'b0, det = 1'b0, clr = 1'b0;
  logic          ev;
  logic [CW-1:0] cnt;
  logic          sat, act;
  logic [1:0]    st;
  logic          val1 = 1'b0, det1 = 1'b0, clr1 = 1'b0;
  logic          ev1;
  logic [CW-1:0] cnt1;
  logic          sat1, act1;
  logic [1:0]    st1;

  int vectors = 0;
  int errors  = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt;

  // clock / reset
  always #5 clk_i = ~clk_i;

  pair_triple_event_counter #(.COUNT_WIDTH(CW), .HOLD_CYCLES(2)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_val_i(val), .in_det_i(det), .clear_i(clr),
    .event_o(ev), .count_o(cnt), .sat_o(sat), .active_o(act), .state_o(st)
  );

  pair_triple_event_counter #(.COUNT_WIDTH(CW), .HOLD_CYCLES(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .in_val_i(val1), .in_det_i(det1), .clear_i(clr1),
    .event_o(ev1), .count_o(cnt1), .sat_o(sat1), .active_o(act1), .state_o(st1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver: apply inputs, take one rising edge, settle 1 time unit past it
  task automatic step(input logic v, input logic d, input logic c);
    val = v; det = d; clr = c;
    @(posedge clk_i); #1;
  endtask

  task automatic step1(input logic v, input logic d);
    val1 = v; det1 = d;
    @(posedge clk_i); #1;
  endtask

  task automatic fire_event();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("rst_event", 32'(ev), 0);
    check("rst_count", 32'(cnt), 0);
    check("rst_sat", 32'(sat), 0);
    check("rst_active", 32'(act), 0);
    check("rst_state", 32'(st), 32'(S_IDLE));

    // scenario 1: 1,1,1,0
    step(1'b1, 1'b1, 1'b0);
    check("s1_arm_active", 32'(act), 1);
    check("s1_arm_event", 32'(ev), 0);
    check("s1_arm_state", 32'(st), 32'(S_ARM));
    step(1'b1, 1'b1, 1'b0);
    check("s1_fire_event", 32'(ev), 1);
    check("s1_fire_count", 32'(cnt), 1);
    check("s1_fire_state", 32'(st), 32'(S_HELD));
    step(1'b1, 1'b1, 1'b0);
    check("s1_held_event", 32'(ev), 0);
    check("s1_held_active", 32'(act), 1);
    check("s1_held_count", 32'(cnt), 1);
    step(1'b1, 1'b0, 1'b0);
    check("s1_idle_active", 32'(act), 0);

    // scenario 2: glitches 1,0,1,0
    step(1'b1, 1'b1, 1'b0);
    check("s2_arm1", 32'(st), 32'(S_ARM));
    step(1'b1, 1'b0, 1'b0);
    check("s2_idle1", 32'(st), 32'(S_IDLE));
    check("s2_ev1", 32'(ev), 0);
    step(1'b1, 1'b1, 1'b0);
    check("s2_arm2", 32'(st), 32'(S_ARM));
    step(1'b1, 1'b0, 1'b0);
    check("s2_idle2", 32'(st), 32'(S_IDLE));
    check("s2_ev2", 32'(ev), 0);
    check("s2_count", 32'(cnt), 1);

    // invalid sample in IDLE is ignored
    step(1'b0, 1'b1, 1'b0);
    check("inval_idle_state", 32'(st), 32'(S_IDLE));

    // scenario 3: in_val gaps keep ARM progress
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("s3_gap_state", 32'(st), 32'(S_ARM));
      check("s3_gap_event", 32'(ev), 0);
    end
    step(1'b1, 1'b1, 1'b0);
    check("s3_fire_event", 32'(ev), 1);
    check("s3_fire_count", 32'(cnt), 2);
    step(1'b1, 1'b0, 1'b0);

    // scenario 4: 16 events from zero
    step(1'b0, 1'b0, 1'b1);
    check("s4_clear_count", 32'(cnt), 0);
    for (int k = 1; k <= 16; k++) begin
`ifdef PAIR_TRIPLE_EVENT_COUNTER_WRAP_EN
      exp_cnt = CW'(k % 16);
`else
      exp_cnt = (k >= 15) ? CW'(15) : CW'(k);
`endif
      exp_q.push_back(exp_cnt);
    end
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("s4_event", 32'(ev), 1);
      check("s4_count", 32'(cnt), 32'(exp_q.pop_front()));
`ifdef PAIR_TRIPLE_EVENT_COUNTER_WRAP_EN
      check("s4_sat", 32'(sat), (k >= 16) ? 1 : 0);
`else
      check("s4_sat", 32'(sat), (k >= 15) ? 1 : 0);
`endif
      step(1'b1, 1'b0, 1'b0);
    end

    // scenario 5: clear collides with firing sample
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) fire_event();
    check("s5_count5", 32'(cnt), 5);
    step(1'b1, 1'b1, 1'b0);
    check("s5_arm", 32'(act), 1);
    step(1'b1, 1'b1, 1'b1);
    check("s5_event", 32'(ev), 0);
    check("s5_count", 32'(cnt), 0);
    check("s5_active", 32'(act), 0);
    check("s5_sat", 32'(sat), 0);
    step(1'b1, 1'b0, 1'b0);

    // scenario 6: async reset mid-ARM
    for (int k = 0; k < 3; k++) fire_event();
    check("s6_count3", 32'(cnt), 3);
    step(1'b1, 1'b1, 1'b0);
    check("s6_arm", 32'(st), 32'(S_ARM));
    #2 rst_i = 1'b1;
    #1;
    check("s6_rst_event", 32'(ev), 0);
    check("s6_rst_count", 32'(cnt), 0);
    check("s6_rst_sat", 32'(sat), 0);
    check("s6_rst_active", 32'(act), 0);
    #1 rst_i = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check("s6_rearm_event", 32'(ev), 0);
    step(1'b1, 1'b1, 1'b0);
    check("s6_after_event", 32'(ev), 1);
    check("s6_after_count", 32'(cnt), 1);
    step(1'b1, 1'b0, 1'b0);

    // HOLD_CYCLES = 1 instance
    step1(1'b1, 1'b1);
    check("h1_event", 32'(ev1), 1);
    check("h1_count", 32'(cnt1), 1);
    check("h1_state", 32'(st1), 32'(S_HELD));
    step1(1'b1, 1'b1);
    check("h1_sustain_event", 32'(ev1), 0);
    check("h1_sustain_count", 32'(cnt1), 1);
    step1(1'b1, 1'b0);
    check("h1_idle_active", 32'(act1), 0);
    step1(1'b1, 1'b1);
    check("h1_event2", 32'(ev1), 1);
    check("h1_count2", 32'(cnt1), 2);
    step1(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
